branch_resolver: RTL and testbench

EX-stage branch resolution unit and the update end of the fetch-side branch predictor interface. Evaluates each conditional branch or jump in EX and computes the true next PC. Compares that PC with the prediction carried down from IF and registers a one-cycle resolution record (`old_*` signals) that the predictor consumes for BHT update and redirect. On a mispredict it also raises flush and squashes the wrong-path instructions that follow in the pipeline.

---
 rtl/branch_resolver_pkg.sv | 24 ++
 rtl/branch_compare.sv | 24 ++
 rtl/branch_resolver.sv | 146 ++++++++++++++
 tb/tb_branch_resolver.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// rtl/branch_resolver_pkg.sv - shared core constants: data width, branch funct3 encodings, squash states
package branch_resolver_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_funct3_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } squash_state_e;

  function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] v);
    return {v[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational branch condition evaluator (funct3, rs1, rs2 -> taken)
module branch_compare
  import branch_resolver_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_data == rs2_data);
      F3_BNE:  taken = (rs1_data != rs2_data);
      F3_BLT:  taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: taken = (rs1_data < rs2_data);
      F3_BGEU: taken = (rs1_data >= rs2_data);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - EX-stage branch resolution, predictor update record, flush and squash; BRANCH_PERF_EN adds perf counters
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            valid,
  input  logic            branch,
  input  logic            predict,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  output logic            old_branch,
  output logic [XLEN-1:0] old_branch_pc,
  output logic [XLEN-1:0] old_predict_pc,
  output logic [XLEN-1:0] old_pc,
  output logic            old_predict,
  output logic            old_actual,
  output logic            flush,
  output logic [31:0]     br_total,
  output logic [31:0]     br_miss
);

  localparam int CW = (SQUASH_DEPTH > 0) ? $clog2(SQUASH_DEPTH + 1) : 1;

  squash_state_e state, state_n;
  logic [CW-1:0] squash_cnt, squash_cnt_n;

  logic            cond_taken;
  logic            taken;
  logic            eligible;
  logic            mispredict;
  logic [XLEN-1:0] target;

  branch_compare u_compare (
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (cond_taken)
  );

  // Jumps (predict=0) are always taken; only conditional branches consult the comparator.
  always_comb begin
    taken = predict ? cond_taken : 1'b1;
    if (!taken)
      target = pc + XLEN'(4);
    else if (jalr)
      target = clear_lsb(rs1_data + imm);
    else
      target = pc + imm;
  end

  assign eligible   = valid && branch && !stall && (state == ST_IDLE);
  assign mispredict = eligible && (target != pred_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      squash_cnt <= '0;
    end else begin
      state      <= state_n;
      squash_cnt <= squash_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    squash_cnt_n = squash_cnt;
    case (state)
      ST_IDLE: begin
        if (mispredict && (SQUASH_DEPTH > 0)) begin
          state_n      = ST_SQUASH;
          squash_cnt_n = CW'(SQUASH_DEPTH);
        end
      end
      ST_SQUASH: begin
        if (!stall) begin
          squash_cnt_n = squash_cnt - CW'(1);
          if (squash_cnt == CW'(1))
            state_n = ST_IDLE;
        end
      end
      default: begin
        state_n      = ST_IDLE;
        squash_cnt_n = '0;
      end
    endcase
  end

  // Data fields keep their last values between records; only the pulse bits clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      old_branch     <= 1'b0;
      flush          <= 1'b0;
      old_branch_pc  <= '0;
      old_predict_pc <= '0;
      old_pc         <= '0;
      old_predict    <= 1'b0;
      old_actual     <= 1'b0;
    end else if (!stall) begin
      if (eligible) begin
        old_branch     <= 1'b1;
        flush          <= mispredict;
        old_branch_pc  <= pc;
        old_predict_pc <= pred_pc;
        old_pc         <= target;
        old_predict    <= pred_taken;
        old_actual     <= taken;
      end else begin
        old_branch <= 1'b0;
        flush      <= 1'b0;
      end
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] br_total_q;
  logic [31:0] br_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_total_q <= '0;
      br_miss_q  <= '0;
    end else if (eligible) begin
      br_total_q <= br_total_q + 32'd1;
      if (mispredict)
        br_miss_q <= br_miss_q + 32'd1;
    end
  end

  assign br_total = br_total_q;
  assign br_miss  = br_miss_q;
`else
  assign br_total = '0;
  assign br_miss  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver (directed vectors, optional BRANCH_PERF_EN)
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst, stall, valid, branch, predict, jalr, pred_taken;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data, pc, imm, pred_pc;
  logic        old_branch, old_predict, old_actual, flush;
  logic [31:0] old_branch_pc, old_predict_pc, old_pc, br_total, br_miss;

  branch_resolver #(.SQUASH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid(valid), .branch(branch),
    .predict(predict), .jalr(jalr), .funct3(funct3), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .pc(pc), .imm(imm), .pred_taken(pred_taken),
    .pred_pc(pred_pc), .old_branch(old_branch), .old_branch_pc(old_branch_pc),
    .old_predict_pc(old_predict_pc), .old_pc(old_pc), .old_predict(old_predict),
    .old_actual(old_actual), .flush(flush), .br_total(br_total), .br_miss(br_miss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] bpc;
    logic [31:0] ppc;
    logic [31:0] npc;
    logic        pr;
    logic        act;
    logic        fl;
  } rec_t;

  rec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          chk_mode = 0;  // 1: all outputs zero, 2: record held, 3: perf counters
  logic [31:0] exp_tot = '0;
  logic [31:0] exp_miss = '0;
  logic        done = 1'b0;

  // Monitor: a record is consumed once, on a sample where it will not be held by stall.
  initial begin
    rec_t e, got;
    logic prev_flush;
    logic done_seen;
    prev_flush = 1'b0;
    done_seen  = 1'b0;
    forever begin
      @(negedge clk);
      if (old_branch && !stall) begin
        total++;
        got = {old_branch_pc, old_predict_pc, old_pc, old_predict, old_actual, flush};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_record got=%h required=none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL record got=%h required=%h", got, e);
          end
        end
      end
      if (flush && !old_branch) begin
        total++;
        bad++;
        $display("FAIL flush_without_record flush=%b old_branch=%b", flush, old_branch);
      end
      if (!stall) begin
        if (flush) begin
          total++;
          if (prev_flush) begin
            bad++;
            $display("FAIL consecutive_flush flush=%b required=0", flush);
          end
        end
        prev_flush = flush;
      end
      case (chk_mode)
        1: begin
          total++;
          if ({old_branch, flush, old_predict, old_actual, old_pc, old_branch_pc,
               old_predict_pc, br_total, br_miss} !== '0) begin
            bad++;
            $display("FAIL reset_state ob=%b fl=%b pc=%h bpc=%h ppc=%h tot=%0d miss=%0d required=all0",
                     old_branch, flush, old_pc, old_branch_pc, old_predict_pc, br_total, br_miss);
          end
        end
        2: begin
          total++;
          if (old_branch !== 1'b1 || flush !== 1'b1 || old_pc !== 32'h202) begin
            bad++;
            $display("FAIL stall_hold ob=%b fl=%b pc=%h required=1 1 00000202",
                     old_branch, flush, old_pc);
          end
        end
        3: begin
          total++;
          if (br_total !== exp_tot || br_miss !== exp_miss) begin
            bad++;
            $display("FAIL perf tot=%0d miss=%0d required=%0d %0d",
                     br_total, br_miss, exp_tot, exp_miss);
          end
        end
        default: ;
      endcase
      if (done && !done_seen) begin
        done_seen = 1'b1;
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_records left=%0d required=0", exp_q.size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic b, input logic p, input logic j, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] bb, input logic [31:0] cpc,
                    input logic [31:0] im, input logic pt, input logic [31:0] ppc);
    valid = 1'b1; branch = b; predict = p; jalr = j; funct3 = f3;
    rs1_data = a; rs2_data = bb; pc = cpc; imm = im; pred_taken = pt; pred_pc = ppc;
  endtask

  task automatic expect_rec(input logic [31:0] bpc, input logic [31:0] ppc, input logic [31:0] npc,
                            input logic pr, input logic act, input logic fl);
    exp_q.push_back({bpc, ppc, npc, pr, act, fl});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    br(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    valid = 1'b0;
    tick(); tick();
    chk_mode = 1;
    tick();
    rst = 1'b0; chk_mode = 0;

    br(1, 1, 0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1, 32'h120);
    expect_rec(32'h100, 32'h120, 32'h120, 1, 1, 0); tick();
    br(1, 1, 0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 32'h204);
    expect_rec(32'h200, 32'h204, 32'h240, 0, 1, 1); tick();
    br(1, 1, 0, 3'b000, 0, 0, 32'h300, 32'h8, 0, 32'h304); tick();
    br(1, 1, 0, 3'b000, 0, 0, 32'h304, 32'h8, 0, 32'h308); tick();
    br(1, 1, 0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 0, 32'h404);
    expect_rec(32'h400, 32'h404, 32'h404, 0, 0, 0); tick();
    br(1, 0, 1, 3'b000, 32'h203, 32'd0, 32'h500, 32'h0, 1, 32'h200);
    expect_rec(32'h500, 32'h200, 32'h202, 1, 1, 1); tick();

    stall = 1'b1; chk_mode = 2;
    br(1, 1, 0, 3'b000, 0, 0, 32'h600, 32'h8, 0, 32'h604);
    tick(); tick(); tick();
    stall = 1'b0; chk_mode = 0;
    tick();
    br(1, 1, 0, 3'b000, 0, 0, 32'h604, 32'h8, 0, 32'h608); tick();

    br(1, 1, 0, 3'b001, 32'd1, 32'd2, 32'h700, 32'h8, 1, 32'h708);
    expect_rec(32'h700, 32'h708, 32'h708, 1, 1, 0); tick();
    br(1, 1, 0, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h800, 32'h10, 0, 32'h804);
    expect_rec(32'h800, 32'h804, 32'h804, 0, 0, 0); tick();
    br(1, 1, 0, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h900, 32'hFFFF_FFF0, 1, 32'h8F0);
    expect_rec(32'h900, 32'h8F0, 32'h8F0, 1, 1, 0); tick();
    br(1, 1, 0, 3'b010, 32'd3, 32'd3, 32'hA00, 32'h40, 0, 32'hA04);
    expect_rec(32'hA00, 32'hA04, 32'hA04, 0, 0, 0); tick();
    br(1, 0, 0, 3'b000, 0, 0, 32'hB00, 32'h100, 1, 32'hC00);
    expect_rec(32'hB00, 32'hC00, 32'hC00, 1, 1, 0); tick();
    br(1, 1, 0, 3'b000, 32'd1, 32'd2, 32'hD00, 32'h4, 1, 32'hD04);
    expect_rec(32'hD00, 32'hD04, 32'hD04, 1, 0, 0); tick();

    br(1, 1, 0, 3'b000, 0, 0, 32'hD10, 32'h80, 0, 32'hD14);
    valid = 1'b0; tick();
    br(0, 1, 0, 3'b000, 0, 0, 32'hD20, 32'h80, 0, 32'hD24); tick();
    br(0, 0, 0, 3'b000, 0, 0, 32'hD30, 32'h80, 0, 32'hD34); tick();

    br(1, 0, 0, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h20, 1, 32'h10);
    expect_rec(32'hFFFF_FFF0, 32'h10, 32'h10, 1, 1, 0); tick();
    br(1, 1, 0, 3'b000, 32'd7, 32'd7, 32'hE00, 32'h80, 0, 32'hE04);
    expect_rec(32'hE00, 32'hE04, 32'hE80, 0, 1, 1); tick();

    valid = 1'b0;
`ifdef BRANCH_PERF_EN
    exp_tot = 32'd12; exp_miss = 32'd3;
`else
    exp_tot = 32'd0; exp_miss = 32'd0;
`endif
    chk_mode = 3;
    tick();
    chk_mode = 0;
    rst = 1'b1; stall = 1'b1;
    tick();
    chk_mode = 1;
    tick();
    rst = 1'b0; stall = 1'b0; chk_mode = 0;

    br(1, 1, 0, 3'b000, 32'd9, 32'd9, 32'hF00, 32'h10, 1, 32'hF10);
    expect_rec(32'hF00, 32'hF10, 32'hF10, 1, 1, 0); tick();
    valid = 1'b0;
`ifdef BRANCH_PERF_EN
    exp_tot = 32'd1; exp_miss = 32'd0;
`endif
    chk_mode = 3;
    tick();
    chk_mode = 0; done = 1'b1;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
